// File: rtl/serv_immdec_wide.sv
// ---------------------------------------------------------------------------
// serv_immdec_wide
//
// Immediate decoder for the bit-serial core, widened to W bits per count
// cycle. A fetched instruction is captured on i_wb_en. Its immediate is
// decoded by type into a 32-bit register, which is then streamed out
// LSB-first, W bits per i_cnt_en. The register addresses are kept in their
// own registers and are never shifted.
//
// Parameters:
//   W                 bits delivered per count cycle (1, 2, 4 or 8)
//   CLR_ADDR_ON_DONE  1: address/zimm outputs clear when a stream completes
//                     0: they hold until the next capture
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_wb_en     instruction capture strobe (fetch ack)
//   i_wb_rdt    instruction bits [31:7]
//   i_imm_type  0=I 1=S 2=B 3=U 4=J 5=CSR-zimm (6,7 decode as I)
//   i_cnt_en    advance one W-bit chunk
//   o_imm       current immediate chunk (0 when idle)
//   o_last      high while the final chunk is presented
//   o_busy      high while a captured immediate is pending or streaming
//   o_done      one-cycle pulse after the final chunk is consumed
//   o_rd_addr   instr[11:7]
//   o_rs1_addr  instr[19:15]
//   o_rs2_addr  instr[24:20]
//   o_csr_imm   instr[15], the zimm LSB
// ---------------------------------------------------------------------------
module serv_immdec_wide #(
  parameter int W                = 1,
  parameter bit CLR_ADDR_ON_DONE = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wb_en,
  input  logic [24:0]   i_wb_rdt,
  input  logic [2:0]    i_imm_type,
  input  logic          i_cnt_en,
  output logic [W-1:0]  o_imm,
  output logic          o_last,
  output logic          o_busy,
  output logic          o_done,
  output logic [4:0]    o_rd_addr,
  output logic [4:0]    o_rs1_addr,
  output logic [4:0]    o_rs2_addr,
  output logic          o_csr_imm
);

  localparam int N  = 32 / W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    SHIFT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   imm_q, imm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    rd_q, rd_d;
  logic [4:0]    rs1_q, rs1_d;
  logic [4:0]    rs2_q, rs2_d;
  logic          csr_imm_q, csr_imm_d;
  logic          done_q, done_d;

  logic [31:0]   instr;
  logic          sign;
  logic [31:0]   dec_imm;
  logic          busy;
  logic          last;

  // The low seven opcode bits are not delivered; pad them so the field
  // slices below read exactly like the ISA manual.
  assign instr = {i_wb_rdt, 7'b0};
  assign sign  = instr[31];

  // Immediate decode from the standard RISC-V formats. CSR zimm is the only
  // format that is zero-extended.
  always_comb begin
    dec_imm = {{20{sign}}, instr[31:20]};
    case (i_imm_type)
      3'd1: dec_imm = {{20{sign}}, instr[31:25], instr[11:7]};
      3'd2: dec_imm = {{20{sign}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      3'd3: dec_imm = {instr[31:12], 12'b0};
      3'd4: dec_imm = {{12{sign}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      3'd5: dec_imm = {27'b0, instr[19:15]};
      default: dec_imm = {{20{sign}}, instr[31:20]};
    endcase
  end

  assign busy = (state_q != IDLE);
  assign last = busy && (cnt_q == LAST_CNT);

  // Next-state logic. A capture always wins over a simultaneous count, so a
  // restart mid-stream simply reloads and never raises done for the stream
  // it abandons. Counts while idle are ignored.
  always_comb begin
    state_d   = state_q;
    imm_d     = imm_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    csr_imm_d = csr_imm_q;
    done_d    = 1'b0;

    if (i_wb_en) begin
      state_d   = LOADED;
      imm_d     = dec_imm;
      cnt_d     = '0;
      rd_d      = instr[11:7];
      rs1_d     = instr[19:15];
      rs2_d     = instr[24:20];
      csr_imm_d = instr[15];
    end else if (busy && i_cnt_en) begin
      imm_d = imm_q >> W;
      if (last) begin
        // Final chunk consumed: back to idle, counter returns to zero.
        state_d = IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
        if (CLR_ADDR_ON_DONE) begin
          rd_d      = '0;
          rs1_d     = '0;
          rs2_d     = '0;
          csr_imm_d = 1'b0;
        end
      end else begin
        state_d = SHIFT;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  // All state, including the registered done pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      imm_q     <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      csr_imm_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      imm_q     <= imm_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      csr_imm_q <= csr_imm_d;
      done_q    <= done_d;
    end
  end

  assign o_imm      = busy ? imm_q[W-1:0] : '0;
  assign o_last     = last;
  assign o_busy     = busy;
  assign o_done     = done_q;
  assign o_rd_addr  = rd_q;
  assign o_rs1_addr = rs1_q;
  assign o_rs2_addr = rs2_q;
  assign o_csr_imm  = csr_imm_q;

endmodule

// File: tb/tb_serv_immdec_wide.sv
// ---------------------------------------------------------------------------
// tb_serv_immdec_wide
//
// Drives five decoder instances (W = 1, 2, 4, 8 holding addresses, and W = 4
// clearing addresses on done) from one shared stimulus stream and compares
// every instance against a behavioural model on every cycle. Directed
// streams from known instructions pin the model with literal immediates and
// addresses, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_serv_immdec_wide;

  localparam int NCFG = 5;

  logic        clk;
  logic        rst_n;
  logic        wb_en;
  logic [24:0] wb_rdt;
  logic [2:0]  imm_type;
  logic        cnt_en;

  logic [7:0]  imm_o  [NCFG];
  logic        last_o [NCFG];
  logic        busy_o [NCFG];
  logic        done_o [NCFG];
  logic [4:0]  rd_o   [NCFG];
  logic [4:0]  rs1_o  [NCFG];
  logic [4:0]  rs2_o  [NCFG];
  logic        csr_o  [NCFG];

  int tests_run;
  int tests_failed;

  // Behavioural model state, one entry per instance.
  logic [31:0] m_imm   [NCFG];
  int          m_idx   [NCFG];
  bit          m_busy  [NCFG];
  bit          m_done  [NCFG];
  logic [4:0]  m_rd    [NCFG];
  logic [4:0]  m_rs1   [NCFG];
  logic [4:0]  m_rs2   [NCFG];
  bit          m_csr   [NCFG];
  logic [31:0] recon   [NCFG];

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance array: index selects width and address-clear behaviour.
  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int WW = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 8 : 4;
    localparam bit CL = (g == 4);
    logic [WW-1:0] imm_w;
    logic [7:0]    imm8;
    logic          l_w, b_w, d_w, c_w;
    logic [4:0]    rd_w, rs1_w, rs2_w;

    serv_immdec_wide #(
      .W               (WW),
      .CLR_ADDR_ON_DONE(CL)
    ) u_dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_wb_en   (wb_en),
      .i_wb_rdt  (wb_rdt),
      .i_imm_type(imm_type),
      .i_cnt_en  (cnt_en),
      .o_imm     (imm_w),
      .o_last    (l_w),
      .o_busy    (b_w),
      .o_done    (d_w),
      .o_rd_addr (rd_w),
      .o_rs1_addr(rs1_w),
      .o_rs2_addr(rs2_w),
      .o_csr_imm (c_w)
    );

    assign imm8        = 8'(imm_w);
    assign imm_o[g]    = imm8;
    assign last_o[g]   = l_w;
    assign busy_o[g]   = b_w;
    assign done_o[g]   = d_w;
    assign rd_o[g]     = rd_w;
    assign rs1_o[g]    = rs1_w;
    assign rs2_o[g]    = rs2_w;
    assign csr_o[g]    = c_w;
  end

  function automatic int cfgW(int c);
    case (c)
      0: return 1;
      1: return 2;
      2: return 4;
      3: return 8;
      default: return 4;
    endcase
  endfunction

  function automatic bit cfgClr(int c);
    return (c == 4);
  endfunction

  // Immediate value per format, written with shifts and masks.
  function automatic logic [31:0] decodeImm(logic [31:0] i, int t);
    logic [31:0] sx;
    logic [31:0] hi;
    sx = i[31] ? 32'hFFFF_FFFF : 32'h0;
    hi = $signed(i) >>> 20;
    case (t)
      1: return (hi & ~32'h1F) | ((i >> 7) & 32'h1F);
      2: return (sx & ~32'hFFF) | (((i >> 7) & 32'h1) << 11)
                | (((i >> 25) & 32'h3F) << 5) | (((i >> 8) & 32'hF) << 1);
      3: return i & 32'hFFFF_F000;
      4: return (sx & ~32'hF_FFFF) | (i & 32'h000F_F000)
                | (((i >> 20) & 32'h1) << 11) | (((i >> 21) & 32'h3FF) << 1);
      5: return (i >> 15) & 32'h1F;
      default: return hi;
    endcase
  endfunction

  function automatic logic [26:0] expVec(int c);
    int          w;
    logic [31:0] chunk;
    logic [31:0] mask;
    bit          lst;
    w     = cfgW(c);
    mask  = (32'h1 << w) - 32'h1;
    chunk = m_busy[c] ? ((m_imm[c] >> (m_idx[c] * w)) & mask) : 32'h0;
    lst   = m_busy[c] && (m_idx[c] == (32 / w) - 1);
    return {chunk[7:0], lst, m_busy[c], m_done[c], m_rd[c], m_rs1[c], m_rs2[c], m_csr[c]};
  endfunction

  function automatic logic [26:0] actVec(int c);
    return {imm_o[c], last_o[c], busy_o[c], done_o[c], rd_o[c], rs1_o[c], rs2_o[c], csr_o[c]};
  endfunction

  task automatic modelReset();
    for (int c = 0; c < NCFG; c++) begin
      m_imm[c]  = '0;
      m_idx[c]  = 0;
      m_busy[c] = 1'b0;
      m_done[c] = 1'b0;
      m_rd[c]   = '0;
      m_rs1[c]  = '0;
      m_rs2[c]  = '0;
      m_csr[c]  = 1'b0;
    end
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic modelStep();
    logic [31:0] instr;
    instr = {wb_rdt, 7'b0};
    for (int c = 0; c < NCFG; c++) begin
      m_done[c] = 1'b0;
      if (!rst_n) begin
        // held in reset; state already cleared
      end else if (wb_en) begin
        m_imm[c]  = decodeImm(instr, int'(imm_type));
        m_idx[c]  = 0;
        m_busy[c] = 1'b1;
        m_rd[c]   = instr[11:7];
        m_rs1[c]  = instr[19:15];
        m_rs2[c]  = instr[24:20];
        m_csr[c]  = instr[15];
        recon[c]  = '0;
      end else if (m_busy[c] && cnt_en) begin
        if (m_idx[c] == (32 / cfgW(c)) - 1) begin
          m_busy[c] = 1'b0;
          m_done[c] = 1'b1;
          m_idx[c]  = 0;
          if (cfgClr(c)) begin
            m_rd[c]  = '0;
            m_rs1[c] = '0;
            m_rs2[c] = '0;
            m_csr[c] = 1'b0;
          end
        end else begin
          m_idx[c] = m_idx[c] + 1;
        end
      end
    end
  endtask

  task automatic checkOutput();
    logic [26:0] a;
    logic [26:0] e;
    for (int c = 0; c < NCFG; c++) begin
      a = actVec(c);
      e = expVec(c);
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("[TB] FAIL cycle_cmp cfg%0d t=%0t actual=%07h expected=%07h", c, $time, a, e);
      end
      if (m_busy[c])
        recon[c] = recon[c] | ({24'h0, imm_o[c]} << (m_idx[c] * cfgW(c)));
    end
  endtask

  task automatic checkLit(string name, logic [31:0] actual, logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s actual=%08h expected=%08h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare at the falling edge.
  task automatic applyStimulus(bit wb, logic [31:0] instr, int t, bit cnt);
    wb_en    = wb;
    wb_rdt   = instr[31:7];
    imm_type = 3'(t);
    cnt_en   = cnt;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  // Capture an instruction, stream it fully on every instance, then check
  // the reassembled immediate against a hand-computed value.
  task automatic runStream(string name, logic [31:0] instr, int t, logic [31:0] expected);
    applyStimulus(1'b1, instr, t, 1'b0);
    for (int k = 0; k < 32; k++) applyStimulus(1'b0, 32'h0, 0, 1'b1);
    applyStimulus(1'b0, 32'h0, 0, 1'b0);
    for (int c = 0; c < NCFG; c++)
      checkLit($sformatf("%s_cfg%0d", name, c), recon[c], expected);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    wb_en        = 1'b0;
    wb_rdt       = '0;
    imm_type     = '0;
    cnt_en       = 1'b0;
    for (int c = 0; c < NCFG; c++) recon[c] = '0;
    modelReset();

    // Reset state.
    @(negedge clk);
    checkOutput();
    applyStimulus(1'b0, 32'h0, 0, 1'b1);
    rst_n = 1'b1;

    // I-type addi x1,x2,-5.
    applyStimulus(1'b1, 32'hFFB1_0093, 0, 1'b0);
    checkLit("addi_rd", {27'h0, rd_o[2]}, 32'd1);
    checkLit("addi_rs1", {27'h0, rs1_o[2]}, 32'd2);
    checkLit("addi_chunk0", {24'h0, imm_o[2]}, 32'hB);
    runStream("addi_imm", 32'hFFB1_0093, 0, 32'hFFFF_FFFB);

    // S-type.
    applyStimulus(1'b1, 32'h0053_2423, 1, 1'b0);
    checkLit("sw_rs1", {27'h0, rs1_o[0]}, 32'd6);
    checkLit("sw_rs2", {27'h0, rs2_o[0]}, 32'd5);
    runStream("sw_imm", 32'h0053_2423, 1, 32'h0000_0008);

    // B-type and J-type.
    runStream("beq_imm", 32'hFE00_0EE3, 2, 32'hFFFF_FFFC);
    runStream("jal_imm", 32'h0080_006F, 4, 32'h0000_0008);

    // U-type and CSR zimm with instr[31] set.
    applyStimulus(1'b1, 32'h1234_51B7, 3, 1'b0);
    checkLit("lui_rd", {27'h0, rd_o[1]}, 32'd3);
    runStream("lui_imm", 32'h1234_51B7, 3, 32'h1234_5000);
    applyStimulus(1'b1, 32'h800F_8073, 5, 1'b0);
    checkLit("csr_zimm_bit", {31'h0, csr_o[1]}, 32'd1);
    runStream("csr_imm", 32'h800F_8073, 5, 32'h0000_001F);
    checkLit("clr_rd_after_done", {27'h0, rd_o[4]}, 32'd0);

    // Restart: capture together with a count mid-stream.
    applyStimulus(1'b1, 32'hFFB1_0093, 0, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 32'h0, 0, 1'b1);
    applyStimulus(1'b1, 32'h1234_51B7, 3, 1'b1);
    checkLit("restart_done", {31'h0, done_o[2]}, 32'd0);
    checkLit("restart_busy", {31'h0, busy_o[2]}, 32'd1);
    for (int k = 0; k < 32; k++) applyStimulus(1'b0, 32'h0, 0, 1'b1);
    applyStimulus(1'b0, 32'h0, 0, 1'b0);
    checkLit("restart_imm", recon[2], 32'h1234_5000);

    // Asynchronous reset between clock edges.
    applyStimulus(1'b1, 32'hFFB1_0093, 0, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 32'h0, 0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 0, 1'b1);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 32'h0, 0, 1'b1);
    checkLit("post_reset_idle", {31'h0, busy_o[2]}, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 15) == 0), $urandom, int'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serv_immdec_wide.md
Name: serv_immdec_wide

Overview:
- Parametrised immediate decoder for the bit-serial core, generalised from 1 bit per cycle to W bits per cycle.
- Captures a fetched instruction on i_wb_en and decodes its immediate by type (I/S/B/U/J/CSR-zimm) into a 32-bit shift register.
- Streams that register LSB-first, W bits per i_cnt_en cycle.
- Owns its own chunk counter and state machine and holds rd/rs1/rs2 addresses in dedicated registers, which are never shifted.

Parameters:
- W, 1, bits delivered per count cycle; legal values 1, 2, 4, 8 (must divide 32).
- CLR_ADDR_ON_DONE, 0, 1: rd/rs1/rs2 address outputs clear to 0 when streaming completes; 0: they hold until the next load.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active low
- i_wb_en  in  1  instruction-capture strobe (fetch ack)
- i_wb_rdt  in  25  instruction bits [31:7]
- i_imm_type  in  3  0=I, 1=S, 2=B, 3=U, 4=J, 5=CSR-zimm; 6,7 decode as I
- i_cnt_en  in  1  advance one W-bit chunk
- o_imm  out  W  current immediate chunk
- o_last  out  1  high while the final chunk is presented
- o_busy  out  1  high in LOADED or SHIFT
- o_done  out  1  one-cycle pulse after the final chunk is consumed
- o_rd_addr  out  5  instr[11:7]
- o_rs1_addr  out  5  instr[19:15]
- o_rs2_addr  out  5  instr[24:20]
- o_csr_imm  out  1  instr[15], zimm LSB, valid while captured

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE; imm register, counter and address registers = 0.
  - Outputs o_imm=0, o_last=0, o_busy=0, o_done=0, all addresses 0, o_csr_imm=0.
- Decode at capture, using the standard RISC-V formats, sign bit instr[31]:
  - I: sext(instr[31:20])
  - S: sext({instr[31:25],instr[11:7]})
  - B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
  - U: {instr[31:12],12'b0}
  - J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
  - CSR: zero-extended instr[19:15]; never sign-extended.
- Counter: N = 32/W chunks; counter width clog2(N), minimum 1.
- State machine (IDLE, LOADED, SHIFT):
  - IDLE --i_wb_en--> LOADED: register decoded imm and addresses; counter=0.
  - LOADED --i_cnt_en--> SHIFT, or LOADED --i_cnt_en--> IDLE if N==1.
  - SHIFT --i_cnt_en with counter==N-1--> IDLE.
- Shift on each i_cnt_en in LOADED/SHIFT: imm <= imm >> W; counter++.
- o_imm = imm[W-1:0] combinationally in LOADED/SHIFT; 0 in IDLE.
  - Latency: chunk k visible in the cycle after the k-th i_cnt_en (chunk 0 visible the cycle after capture).
- o_last = busy & (counter==N-1).
- o_done pulses for exactly 1 cycle after the cnt_en that consumed the last chunk.
- i_cnt_en in IDLE: ignored; no state change, o_imm stays 0.
- Simultaneous i_wb_en & i_cnt_en: the capture wins. Imm reloads, counter=0, state=LOADED, no shift, no o_done.
- i_wb_en in SHIFT (restart): abort the current stream, reload and go to LOADED. No o_done for the aborted stream.
- Addresses and o_csr_imm:
  - Update only on capture.
  - In IDLE after done: cleared if CLR_ADDR_ON_DONE=1, otherwise held.
- Async reset asserted mid-stream: immediately to reset values. After deassertion the block stays in IDLE until a capture.
- Counter wrap: never wraps silently; it returns to 0 only via done or capture.

Test Plan:
- W=4, I-type, instr 0xFFB10093 (addi x1,x2,-5), 8 cnt_en -> o_imm B,F,F,F,F,F,F,F; o_rd_addr=1, o_rs1_addr=2; o_last on 8th chunk; o_done 1 cycle later.
- W=1, S-type 0x00532423 -> serial bits reconstruct 0x00000008; rs1=6, rs2=5; o_last exactly at bit 31.
- W=8, B-type 0xFE000EE3 -> chunks FC,FF,FF,FF; then J-type 0x0080006F -> 08,00,00,00.
- W=2, U-type 0x123451B7 -> reconstructed 0x12345000, rd=3; then CSR type with instr[19:15]=31 and instr[31]=1 -> 0x0000001F, o_csr_imm=1.
- W=4: capture, 3 cnt_en, then i_wb_en together with i_cnt_en -> reload, counter=0, no o_done; new stream completes in 8 chunks.
- W=4: assert i_rst_n=0 mid-stream, without a clock edge -> all outputs 0 immediately; after release, cnt_en pulses are ignored until the next i_wb_en.
